trng_entropy_reader: RTL and testbench

Consumer end of the TRNG raw bit stream. Samples the serial bit from the ring-oscillator source and runs continuous health tests on it: a repetition-count test (RCT) and an adaptive-proportion test (APT). It assembles bits into bytes in the same MSB-first shift order as the source and delivers them to downstream logic through a small FIFO with a valid/ready handshake. On any health failure it blocks all output until explicitly cleared.

---
 rtl/trng_entropy_reader.sv | 267 ++++++++++++++++++++++++++
 tb/tb_trng_entropy_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/trng_entropy_reader.sv
// trng_entropy_reader
// Consumer end of the TRNG raw bit stream. Accepted bits are health-tested
// continuously with a repetition-count test (RCT) and an adaptive-proportion
// test (APT). The first STARTUP_BITS accepted bits are tested and then thrown
// away. After that, bits are packed MSB-first into bytes and handed out
// through a small FIFO with a valid/ready handshake. A health trip blocks all
// output until clear_fail is pulsed.
//
// Ports
//   clk          system clock
//   n_reset      synchronous, active-low reset
//   enable       run request
//   raw_bit      entropy bit from the source
//   raw_valid    qualifies raw_bit
//   clear_fail   pulse that leaves FAIL
//   byte_out     FIFO head byte (0 when the FIFO is empty)
//   byte_valid   FIFO non-empty
//   byte_ready   downstream accepts byte_out
//   health_fail  high while in FAIL
//   fail_cause   01 RCT, 10 APT, 11 both; held while in FAIL
//   state        00 IDLE, 01 STARTUP, 10 RUN, 11 FAIL
//   drop_count   saturating count of bytes lost to a full FIFO
module trng_entropy_reader #(
  parameter int RCT_CUTOFF   = 16,
  parameter int APT_WINDOW   = 256,
  parameter int APT_CUTOFF   = 200,
  parameter int STARTUP_BITS = 1024,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       enable,
  input  logic       raw_bit,
  input  logic       raw_valid,
  input  logic       clear_fail,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       health_fail,
  output logic [1:0] fail_cause,
  output logic [1:0] state,
  output logic [7:0] drop_count
);

  localparam int RUN_W  = $clog2(RCT_CUTOFF + 1);
  localparam int APT_PW = $clog2(APT_WINDOW);
  localparam int APT_CW = $clog2(APT_WINDOW + 1);
  localparam int SU_W   = $clog2(STARTUP_BITS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [RUN_W-1:0]  RCT_LIM = RUN_W'(RCT_CUTOFF);
  localparam logic [APT_CW-1:0] APT_LIM = APT_CW'(APT_CUTOFF);
  localparam logic [SU_W-1:0]   SU_LAST = SU_W'(STARTUP_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_STARTUP = 2'b01,
    ST_RUN     = 2'b10,
    ST_FAIL    = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               prev_q, prev_d;
  logic [APT_PW-1:0]  apt_pos_q, apt_pos_d;
  logic               apt_ref_q, apt_ref_d;
  logic [APT_CW-1:0]  apt_cnt_q, apt_cnt_d;
  logic [SU_W-1:0]    su_cnt_q, su_cnt_d;
  logic [7:0]         acc_q, acc_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]         cause_q, cause_d;
  logic [7:0]         drop_q, drop_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               accept_s;
  logic [RUN_W-1:0]   run_next_s;
  logic [APT_CW-1:0]  apt_cnt_next_s;
  logic               rct_trip_s, apt_trip_s, trip_s;
  logic               su_done_s;
  logic               fifo_empty_s, fifo_full_s;
  logic               pop_s, byte_push_s, push_ok_s, drop_s;
  logic               clear_s;
  logic [7:0]         new_byte_s;

  // Health-test arithmetic evaluated on the bit being accepted this cycle
  always_comb begin
    accept_s = raw_valid & enable & ((state_q == ST_STARTUP) | (state_q == ST_RUN));
    // run_q == 0 means no bit seen since IDLE, so the next bit starts a run of 1
    if ((run_q != {RUN_W{1'b0}}) && (raw_bit == prev_q)) begin
      run_next_s = run_q + RUN_W'(1);
    end else begin
      run_next_s = RUN_W'(1);
    end
    if (apt_pos_q == {APT_PW{1'b0}}) begin
      apt_cnt_next_s = APT_CW'(1);
    end else begin
      apt_cnt_next_s = apt_cnt_q + APT_CW'(raw_bit == apt_ref_q);
    end
    rct_trip_s  = accept_s & (run_next_s >= RCT_LIM);
    apt_trip_s  = accept_s & (apt_cnt_next_s >= APT_LIM);
    trip_s      = rct_trip_s | apt_trip_s;
    su_done_s   = accept_s & (state_q == ST_STARTUP) & (su_cnt_q == SU_LAST);
    new_byte_s  = {acc_q[6:0], raw_bit};
  end

  // FIFO status and handshake
  always_comb begin
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop_s        = ~fifo_empty_s & byte_ready;
    byte_push_s  = accept_s & (state_q == ST_RUN) & ~trip_s & (bit_cnt_q == 3'd7);
    // A pop on the same edge frees the slot, so a full FIFO still takes the byte
    push_ok_s    = byte_push_s & (~fifo_full_s | pop_s);
    drop_s       = byte_push_s & fifo_full_s & ~pop_s;
  end

  // Next-state logic of the control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_STARTUP;
        else        state_d = ST_IDLE;
      end
      ST_STARTUP: begin
        if (!enable)        state_d = ST_IDLE;
        else if (trip_s)    state_d = ST_FAIL;
        else if (su_done_s) state_d = ST_RUN;
        else                state_d = ST_STARTUP;
      end
      ST_RUN: begin
        if (!enable)     state_d = ST_IDLE;
        else if (trip_s) state_d = ST_FAIL;
        else             state_d = ST_RUN;
      end
      ST_FAIL: begin
        if (clear_fail) state_d = ST_IDLE;
        else            state_d = ST_FAIL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of test, startup, assembler, FIFO and status registers
  always_comb begin
    clear_s   = (state_d == ST_IDLE) || (state_d == ST_FAIL);
    run_d     = run_q;
    prev_d    = prev_q;
    apt_pos_d = apt_pos_q;
    apt_ref_d = apt_ref_q;
    apt_cnt_d = apt_cnt_q;
    su_cnt_d  = su_cnt_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    drop_d    = drop_q;
    cause_d   = 2'b00;

    if (clear_s) begin
      // Entering IDLE or FAIL drops all in-flight state, including the FIFO
      run_d     = {RUN_W{1'b0}};
      prev_d    = 1'b0;
      apt_pos_d = {APT_PW{1'b0}};
      apt_ref_d = 1'b0;
      apt_cnt_d = {APT_CW{1'b0}};
      su_cnt_d  = {SU_W{1'b0}};
      acc_d     = 8'h00;
      bit_cnt_d = 3'd0;
      wr_ptr_d  = {(PTR_W+1){1'b0}};
      rd_ptr_d  = {(PTR_W+1){1'b0}};
    end else begin
      if (accept_s) begin
        run_d     = run_next_s;
        prev_d    = raw_bit;
        apt_cnt_d = apt_cnt_next_s;
        apt_pos_d = apt_pos_q + APT_PW'(1);
        if (apt_pos_q == {APT_PW{1'b0}}) begin
          apt_ref_d = raw_bit;
        end else begin
          apt_ref_d = apt_ref_q;
        end
        if (state_q == ST_STARTUP) begin
          su_cnt_d = su_cnt_q + SU_W'(1);
        end else if (bit_cnt_q == 3'd7) begin
          // The completed byte goes straight to the FIFO, never into acc
          acc_d     = 8'h00;
          bit_cnt_d = 3'd0;
        end else begin
          acc_d     = new_byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end else begin
        run_d = run_q;
      end
      if (push_ok_s) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (pop_s)     rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      else           rd_ptr_d = rd_ptr_q;
    end

    if (drop_s && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    else                             drop_d = drop_q;

    if (state_d == ST_FAIL) begin
      if (state_q == ST_FAIL) cause_d = cause_q;
      else                    cause_d = {apt_trip_s, rct_trip_s};
    end else begin
      cause_d = 2'b00;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      run_q     <= {RUN_W{1'b0}};
      prev_q    <= 1'b0;
      apt_pos_q <= {APT_PW{1'b0}};
      apt_ref_q <= 1'b0;
      apt_cnt_q <= {APT_CW{1'b0}};
      su_cnt_q  <= {SU_W{1'b0}};
      acc_q     <= 8'h00;
      bit_cnt_q <= 3'd0;
      cause_q   <= 2'b00;
      drop_q    <= 8'h00;
      wr_ptr_q  <= {(PTR_W+1){1'b0}};
      rd_ptr_q  <= {(PTR_W+1){1'b0}};
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      prev_q    <= prev_d;
      apt_pos_q <= apt_pos_d;
      apt_ref_q <= apt_ref_d;
      apt_cnt_q <= apt_cnt_d;
      su_cnt_q  <= su_cnt_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      cause_q   <= cause_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= new_byte_s;
    end else begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= mem_q[wr_ptr_q[PTR_W-1:0]];
    end
  end

  assign byte_valid  = ~fifo_empty_s;
  assign byte_out    = fifo_empty_s ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign health_fail = (state_q == ST_FAIL);
  assign fail_cause  = cause_q;
  assign state       = state_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_trng_entropy_reader.sv
// Randomized self-checking bench for trng_entropy_reader with a queue-based
// reference model of the health tests, assembler and output FIFO.
module tb_trng_entropy_reader;

  logic       clk = 1'b0;
  logic       n_reset, enable, raw_bit, raw_valid, clear_fail, byte_ready;
  logic [7:0] byte_out, drop_count;
  logic       byte_valid, health_fail;
  logic [1:0] fail_cause, state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  int         m_state, m_cause, m_drop;
  int         m_run, m_winpos, m_cnt, m_scount;
  bit         m_seen, m_prev, m_ref;
  bit         m_bits[$];
  logic [7:0] m_fifo[$];

  trng_entropy_reader dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .enable     (enable),
    .raw_bit    (raw_bit),
    .raw_valid  (raw_valid),
    .clear_fail (clear_fail),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .health_fail(health_fail),
    .fail_cause (fail_cause),
    .state      (state),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic clear_tests();
    m_seen = 0; m_run = 0; m_winpos = 0; m_cnt = 0; m_scount = 0;
    m_bits.delete();
  endtask

  task automatic model_step(input bit nr, input bit en, input bit rv, input bit rb,
                            input bit clr, input bit rdy);
    bit pop, flush, have, rt, at;
    logic [7:0] nb;
    flush = 0; have = 0; nb = 8'h00;
    pop = (m_fifo.size() != 0) && rdy;
    if (!nr) begin
      m_state = 0; m_cause = 0; m_drop = 0;
      clear_tests();
      m_fifo.delete();
      return;
    end
    case (m_state)
      0: if (en) m_state = 1;
      3: if (clr) begin m_state = 0; m_cause = 0; clear_tests(); end
      default: begin
        if (!en) begin
          m_state = 0; flush = 1; clear_tests();
        end else if (rv) begin
          m_run = (m_seen && rb == m_prev) ? m_run + 1 : 1;
          m_prev = rb; m_seen = 1;
          if (m_winpos == 0) begin m_ref = rb; m_cnt = 1; end
          else if (rb == m_ref) m_cnt++;
          m_winpos = (m_winpos + 1) % 256;
          rt = (m_run >= 16);
          at = (m_cnt >= 200);
          if (rt || at) begin
            m_state = 3; m_cause = {at, rt}; flush = 1; m_bits.delete();
          end else if (m_state == 1) begin
            m_scount++;
            if (m_scount == 1024) m_state = 2;
          end else begin
            m_bits.push_back(rb);
            if (m_bits.size() == 8) begin
              foreach (m_bits[i]) nb = {nb[6:0], m_bits[i]};
              have = 1;
              m_bits.delete();
            end
          end
        end
      end
    endcase
    if (flush) m_fifo.delete();
    else begin
      if (pop) void'(m_fifo.pop_front());
      if (have) begin
        if (m_fifo.size() < 4) m_fifo.push_back(nb);
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("health_fail", 32'(health_fail), 32'(m_state == 3));
    check_eq("fail_cause", 32'(fail_cause), 32'(m_cause));
    check_eq("byte_valid", 32'(byte_valid), 32'(m_fifo.size() != 0));
    check_eq("byte_out", 32'(byte_out), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'h0);
    check_eq("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic step(input bit nr, input bit en, input bit rv, input bit rb,
                      input bit clr, input bit rdy);
    n_reset = nr; enable = en; raw_valid = rv; raw_bit = rb;
    clear_fail = clr; byte_ready = rdy;
    @(posedge clk);
    model_step(nr, en, rv, rb, clr, rdy);
    #1;
    compare_all();
  endtask

  initial begin
    bit tog;
    int k, guard;
    tog = 1'b1;

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("reset_state", 32'(state), 32'h0);

    // Alternating stream through STARTUP into RUN
    for (int i = 0; i < 1150; i++) begin
      step(1'b1, 1'b1, 1'b1, tog, 1'b0, 1'b1);
      tog = ~tog;
    end
    check_eq("run_reached", 32'(state), 32'h2);

    // Downstream stalls: FIFO fills and bytes are dropped
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b1, 1'b1, tog, 1'b0, 1'b0);
      tog = ~tog;
    end
    check_eq("stall_valid", 32'(byte_valid), 32'h1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, ($urandom_range(0, 1) == 0), tog, 1'b0, 1'b1);
      tog = ~tog;
    end

    // Sixteen identical bits trip the RCT
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("rct_cause", 32'(fail_cause), 32'h1);
    check_eq("rct_fail", 32'(health_fail), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("cleared_idle", 32'(state), 32'h0);

    // Fifteen ones then a zero: APT trips, RCT never does
    k = 0;
    for (int i = 0; i < 320; i++) begin
      bit acc_now;
      acc_now = (m_state == 1 || m_state == 2);
      step(1'b1, 1'b1, 1'b1, (k % 16) != 15, 1'b0, 1'b1);
      if (acc_now) k++;
    end
    check_eq("apt_cause", 32'(fail_cause), 32'h2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized operation
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 2999) != 0),
           ($urandom_range(0, 2999) != 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) != 0));
    end

    // Reset in RUN with bytes pending and drops recorded
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!(m_state == 2 && m_drop >= 3) && guard < 3000) begin
      step(1'b1, 1'b1, 1'b1, tog, 1'b0, 1'b0);
      tog = ~tog;
      guard++;
    end
    check_eq("drop_setup_timeout", 32'(guard < 3000), 32'h1);
    check_eq("pre_reset_drop", 32'(drop_count), 32'h3);
    step(1'b0, 1'b1, 1'b1, tog, 1'b0, 1'b0);
    check_eq("rst_state", 32'(state), 32'h0);
    check_eq("rst_valid", 32'(byte_valid), 32'h0);
    check_eq("rst_byte", 32'(byte_out), 32'h0);
    check_eq("rst_drop", 32'(drop_count), 32'h0);
    check_eq("rst_fail", 32'(health_fail), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
